// File: rtl/fortune_scroller.sv
// fortune_scroller: fetches a fortune's 7-segment characters from a 1-cycle ROM and scrolls them
// right-to-left across hex3..hex0. Optional macro FORTUNE_LOOP_EN repeats the scroll forever.
module fortune_scroller #(
  parameter int TICK_DIV = 25000000,
  parameter int MSG_LEN  = 16,
  parameter int IDX_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [6:0]         fortune_id,
  output logic               rom_rd,
  output logic [7+IDX_W-1:0] rom_addr,
  input  logic [6:0]         rom_data,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic [6:0]         hex3,
  output logic               busy,
  output logic               done,
  output logic [2:0]         dbg_state
);
  localparam int STEP_W = ($clog2(MSG_LEN + 5) > IDX_W + 1) ? $clog2(MSG_LEN + 5) : IDX_W + 1;
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_MSG = STEP_W'(MSG_LEN);
  localparam logic [STEP_W-1:0] STEP_END = STEP_W'(MSG_LEN + 4);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [6:0]        BLANK    = 7'h7F;

  // Handshake: start is a one-cycle request, accepted only on a clock edge where the block
  // can take it (IDLE, or any state in loop mode); no back-pressure is given to the requester.
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t              r_state;
  logic [6:0]          r_fid;
  logic [STEP_W-1:0]   r_step;
  logic [DIV_W-1:0]    r_div;
  logic                r_rom_rd;
  logic [7+IDX_W-1:0]  r_rom_addr;
  logic [6:0]          r_hex0, r_hex1, r_hex2, r_hex3;
  logic                r_done;

  logic                w_accept;
  logic [STEP_W-1:0]   w_step_nxt;
  logic                w_nxt_real;

`ifdef FORTUNE_LOOP_EN
  assign w_accept = start;
`else
  assign w_accept = start && (r_state == S_IDLE);
`endif
  assign w_step_nxt = r_step + 1'b1;
  assign w_nxt_real = (w_step_nxt < STEP_MSG);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_fid      <= '0;
      r_step     <= '0;
      r_div      <= '0;
      r_rom_rd   <= 1'b0;
      r_rom_addr <= '0;
      r_hex0     <= BLANK;
      r_hex1     <= BLANK;
      r_hex2     <= BLANK;
      r_hex3     <= BLANK;
      r_done     <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_rom_rd <= 1'b0;
      if (w_accept) begin
        // Step 0 is always a real character, so the first FETCH always reads.
        r_fid      <= fortune_id;
        r_step     <= '0;
        r_hex0     <= BLANK;
        r_hex1     <= BLANK;
        r_hex2     <= BLANK;
        r_hex3     <= BLANK;
        r_rom_rd   <= 1'b1;
        r_rom_addr <= {fortune_id, IDX_W'(0)};
        r_state    <= S_FETCH;
      end else begin
        case (r_state)
          S_FETCH: r_state <= S_WAIT;
          S_WAIT: begin
            r_hex3  <= r_hex2;
            r_hex2  <= r_hex1;
            r_hex1  <= r_hex0;
            r_hex0  <= (r_step < STEP_MSG) ? rom_data : BLANK;
            r_div   <= '0;
            r_state <= S_HOLD;
          end
          S_HOLD: begin
            if (r_div == DIV_LAST) begin
              if (w_step_nxt == STEP_END) begin
                r_done <= 1'b1;
`ifdef FORTUNE_LOOP_EN
                r_step     <= '0;
                r_rom_rd   <= 1'b1;
                r_rom_addr <= {r_fid, IDX_W'(0)};
                r_state    <= S_FETCH;
`else
                r_step  <= w_step_nxt;
                r_state <= S_DONE;
`endif
              end else begin
                // Flush steps leave rom_addr parked on the last real character.
                r_step  <= w_step_nxt;
                r_state <= S_FETCH;
                if (w_nxt_real) begin
                  r_rom_rd   <= 1'b1;
                  r_rom_addr <= {r_fid, w_step_nxt[IDX_W-1:0]};
                end
              end
            end else begin
              r_div <= r_div + 1'b1;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rom_rd    = r_rom_rd;
  assign rom_addr  = r_rom_addr;
  assign hex0      = r_hex0;
  assign hex1      = r_hex1;
  assign hex2      = r_hex2;
  assign hex3      = r_hex3;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_fortune_scroller.sv
// tb_fortune_scroller: directed bench for fortune_scroller with a cycle-level behavioural model.
// Build with FORTUNE_LOOP_EN defined to exercise the looping variant.
module tb_fortune_scroller;
  localparam int TICK_DIV = 4;
  localparam int MSG_LEN  = 4;
  localparam int IDX_W    = 4;
  localparam int AW       = 7 + IDX_W;
  localparam int OUT_W    = 3 + AW + 28;
  localparam int STEP_CYC = 2 + TICK_DIV;
  localparam int PASS_CYC = (MSG_LEN + 4) * STEP_CYC;
  localparam int DONE_N   = 1 + PASS_CYC;
`ifdef FORTUNE_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [6:0]    fortune_id;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [6:0]    rom_data;
  logic [6:0]    hex0, hex1, hex2, hex3;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  fortune_scroller #(.TICK_DIV(TICK_DIV), .MSG_LEN(MSG_LEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .fortune_id(fortune_id),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // ---------------- message ROM (1-cycle read latency) ----------------
  function automatic logic [6:0] rom_val(input logic [AW-1:0] a);
    case (a)
      11'h050: rom_val = 7'h40;
      11'h051: rom_val = 7'h79;
      11'h052: rom_val = 7'h24;
      11'h053: rom_val = 7'h30;
      default: rom_val = a[6:0] ^ 7'h15;
    endcase
  endfunction

  initial rom_data = 7'h7F;
  always @(posedge clk) if (rom_rd) rom_data <= rom_val(rom_addr);

  // ---------------- behavioural model ----------------
  bit            m_active = 1'b0;
  int            m_t0 = 0;
  logic [6:0]    m_fid = '0;
  logic [AW-1:0] m_last_addr = '0;
  logic [OUT_W-1:0] exp_q[$];

  // Expected outputs for the current cycle: a pass is a window sliding over the
  // message padded with four blanks, one step every STEP_CYC cycles.
  function automatic logic [OUT_W-1:0] model_out();
    logic b, d, rd;
    logic [AW-1:0] a;
    logic [6:0] h [4];
    int n, np, s, m, idx;
    b = 1'b0; d = 1'b0; rd = 1'b0; a = m_last_addr;
    for (int j = 0; j < 4; j++) h[j] = 7'h7F;
    if (m_active) begin
      n = cyc - m_t0;
      if (n >= 1) begin
        if (LOOP) np = ((n - 1) % PASS_CYC) + 1;
        else      np = (n > DONE_N) ? DONE_N : n;
        b  = LOOP || (n <= DONE_N);
        d  = LOOP ? (n > 1 && np == 1) : (n == DONE_N);
        s  = (np - 1) / STEP_CYC;
        rd = b && ((np - 1) % STEP_CYC == 0) && (s < MSG_LEN);
        a  = {m_fid, IDX_W'((s < MSG_LEN) ? s : MSG_LEN - 1)};
        m  = (np >= 3) ? ((np - 3) / STEP_CYC + 1) : 0;
        for (int j = 0; j < 4; j++) begin
          idx = m - 1 - j;
          if (idx >= 0 && idx < MSG_LEN) h[j] = rom_val({m_fid, IDX_W'(idx)});
        end
      end
    end
    model_out = {b, d, rd, a, h[3], h[2], h[1], h[0]};
  endfunction

  always @(posedge clk) begin
    logic [OUT_W-1:0] cur;
    cur = model_out();
    if (reset) begin
      m_active    = 1'b0;
      m_last_addr = '0;
    end else if (start && (LOOP || !m_active || (cyc - m_t0) > DONE_N)) begin
      m_last_addr = cur[AW+27:28];
      m_active    = 1'b1;
      m_t0        = cyc;
      m_fid       = fortune_id;
    end
    cyc++;
    exp_q.push_back(model_out());
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [OUT_W-1:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {busy, done, rom_rd, rom_addr, hex3, hex2, hex1, hex0};
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL outputs cycle %0d: got %h expected %h", cyc, g, e);
      end
    end
  end

  // ---------------- driver / directed checks ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic at_cycle(input int c);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < c && guard < 1000);
    if (cyc != c) chk("at_cycle_bound", 64'(cyc), 64'(c));
  endtask

  task automatic drive_at(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  function automatic logic [27:0] hexes();
    hexes = {hex3, hex2, hex1, hex0};
  endfunction

  int b, b2, b3;

  initial begin
    reset = 1'b1; start = 1'b0; fortune_id = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hex", 64'(hexes()), 64'hFFFFFFF);
    chk("reset_rd_busy_done", {rom_rd, busy, done}, 3'b000);
    chk("reset_addr", 64'(rom_addr), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    b = cyc;
    start = 1'b1; fortune_id = 7'h05;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifndef FORTUNE_LOOP_EN
    at_cycle(b + 1);  chk("fetch0", {rom_rd, rom_addr}, {1'b1, 11'h050});
    at_cycle(b + 3);  chk("hex0_first", 64'(hex0), 7'h40);
    at_cycle(b + 7);  chk("fetch1", {rom_rd, rom_addr}, {1'b1, 11'h051});
    drive_at(b + 10); start = 1'b1; fortune_id = 7'h12;
    drive_at(b + 11); start = 1'b0;
    at_cycle(b + 13); chk("fetch2", {rom_rd, rom_addr}, {1'b1, 11'h052});
    at_cycle(b + 19); chk("fetch3", {rom_rd, rom_addr}, {1'b1, 11'h053});
    at_cycle(b + 21); chk("full_text", 64'(hexes()), 64'({7'h40, 7'h79, 7'h24, 7'h30}));
    at_cycle(b + 25); chk("flush_fetch", {rom_rd, rom_addr}, {1'b0, 11'h053});
    at_cycle(b + 48); chk("pre_done", {busy, done}, 2'b10);
    at_cycle(b + 49); chk("done_pulse", {busy, done}, 2'b11);
    chk("flushed_hex", 64'(hexes()), 64'hFFFFFFF);
    drive_at(b + 50); start = 1'b1; fortune_id = 7'h33;
    at_cycle(b + 50); chk("idle_after_done", {busy, done}, 2'b00);
    drive_at(b + 51); start = 1'b0;
    at_cycle(b + 51); chk("b2b_fetch", {rom_rd, rom_addr}, {1'b1, 11'h330});

    b2 = b + 50;
    drive_at(b2 + 15); reset = 1'b1;
    drive_at(b2 + 16); reset = 1'b0;
    at_cycle(b2 + 16);
    chk("midreset_hex", 64'(hexes()), 64'hFFFFFFF);
    chk("midreset_ctl", {busy, rom_rd, done}, 3'b000);
    drive_at(b2 + 20); start = 1'b1; fortune_id = 7'h12;
    drive_at(b2 + 21); start = 1'b0;
    at_cycle(b2 + 21); chk("restart_fetch", {rom_rd, rom_addr}, {1'b1, 11'h120});
    b3 = b2 + 20;
    at_cycle(b3 + 49); chk("done_pass3", {busy, done}, 2'b11);
    at_cycle(b3 + 50); chk("idle_pass3", 64'(busy), 0);
`else
    at_cycle(b + 1);  chk("fetch0", {rom_rd, rom_addr}, {1'b1, 11'h050});
    at_cycle(b + 21); chk("full_text", 64'(hexes()), 64'({7'h40, 7'h79, 7'h24, 7'h30}));
    at_cycle(b + 49); chk("loop_done", {busy, done, rom_rd, rom_addr}, {3'b111, 11'h050});
    at_cycle(b + 50); chk("loop_after", {busy, done}, 2'b10);
    drive_at(b + 60); start = 1'b1; fortune_id = 7'h12;
    drive_at(b + 61); start = 1'b0;
    at_cycle(b + 61);
    chk("loop_restart", {rom_rd, rom_addr}, {1'b1, 11'h120});
    chk("loop_restart_hex", 64'(hexes()), 64'hFFFFFFF);
    at_cycle(b + 109); chk("loop_done2", {busy, done, rom_rd, rom_addr}, {3'b111, 11'h120});
`endif
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
